tmds_channel_decoder: RTL and testbench
=======================================

Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI transmitter's per-channel TMDS encoder.
- Accepts unaligned 10-bit words from a 1:10 deserializer, one per clk_pixel cycle.
- Finds the symbol boundary using control-period tokens, then decodes each aligned symbol into 8-bit video data or a 2-bit control value.
- Three instances, one per TMDS channel, form the HDMI sink front end.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens required in CONFIRM before entering LOCKED.
- SEARCH_WINDOW, 2048: cycles spent at one bit offset looking for a control token before trying the next offset.
- LOSS_WINDOW, 4096: cycles without any control token while LOCKED before lock is dropped.

Ports:
- clk_pixel  input  1  pixel clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tmds_raw  input  10  deserialized word; bit 0 is the earliest-received serial bit.
- locked  output  1  high while the FSM is in LOCKED.
- bit_offset  output  4  current alignment offset, 0..9.
- symbol_valid  output  1  high when data/ctrl/is_ctrl describe a decoded symbol; equals locked delayed to match the output pipeline.
- is_ctrl  output  1  1 = control token, 0 = video data symbol.
- ctrl  output  2  decoded control bits {c1,c0}; valid when is_ctrl=1.
- data  output  8  decoded video byte; valid when is_ctrl=0.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all outputs to 0 and bit_offset to 0;
  - the FSM to SEARCH and all counters to 0;
  - the history registers to 0.
- Stage 1: register prev <= cur and cur <= tmds_raw. Form hist = {cur, prev} (20 bits). Aligned word w = hist[bit_offset+9 : bit_offset].
- Control tokens (w to {c1,c0}):
  - 10'b1101010100 -> 00
  - 10'b0010101011 -> 01
  - 10'b0101010100 -> 10
  - 10'b1010101011 -> 11
- Video decode:
  - if w[9]=1, invert w[7:0];
  - data[0] = w[0];
  - data[i] = w[8] ? w[i]^w[i-1] : ~(w[i]^w[i-1]) for i = 1..7, where w[i] denotes the post-inversion bits.
- Stage 2 registers data, ctrl, is_ctrl and symbol_valid.
- Latency: a word whose last bit enters tmds_raw on cycle t appears on the outputs at cycle t+2.
- FSM states and transitions:
  - SEARCH:
    - If a token is detected, go to CONFIRM with tok_cnt=1.
    - Otherwise, when the window counter reaches SEARCH_WINDOW-1, set bit_offset = (bit_offset==9) ? 0 : bit_offset+1 and clear the window counter.
  - CONFIRM:
    - A token increments tok_cnt; reaching LOCK_COUNT goes to LOCKED.
    - A non-token goes to SEARCH, advances bit_offset by 1 (wrapping 9 to 0) and clears the counters.
  - LOCKED:
    - The loss counter clears on any token and otherwise increments.
    - On reaching LOSS_WINDOW-1, go to SEARCH, keep bit_offset and clear the counters.
- Skipping history after an offset change: after any bit_offset change, the next 2 cycles are not evaluated for tokens, because their history is stale.
- bit_offset changes only in SEARCH or on a CONFIRM failure. It never changes while LOCKED.
- symbol_valid pipeline: locked rises on the cycle the FSM enters LOCKED. symbol_valid is locked delayed to align with the stage-2 outputs and falls in the same alignment when lock drops.
- Counter widths: $clog2 of each window. Counters saturate and never wrap while their state persists.
- Reset asserted mid-operation immediately forces the reset values and lock is lost. After reset is released, alignment restarts at offset 0.

Optional Feature:
- Macro: TMDS_TERC4_DECODE_EN.
- When defined:
  - adds output ports terc4_hit (1 bit) and terc4 (4 bits), registered in stage 2 alongside data;
  - terc4_hit=1 when w matches one of the 16 HDMI TERC4 codes, with terc4 set to that code's nibble;
  - terc4 is decoded in parallel with video decode and does not change the video outputs or the FSM.
- When not defined:
  - the ports and the logic are absent;
  - behaviour is exactly as described above.

Test Plan:
- Reset: assert reset mid-stream -> locked=0, symbol_valid=0, bit_offset=0 asynchronously. Outputs stay at 0 until relock.
- Alignment: continuous control token 00 serialized with a 3-bit skew -> bit_offset reaches 3, locked=1 after LOCK_COUNT tokens, then is_ctrl=1 and ctrl=00 every cycle.
- Video decode: after lock, aligned 10'b0100000000 -> data=8'h00; 10'b1011111111 -> data=8'hFE. Both with is_ctrl=0 and exactly 2 cycles of latency.
- CONFIRM failure: 3 tokens then a video symbol at the candidate offset -> back to SEARCH, bit_offset incremented by 1, locked stays 0.
- Loss of lock: after lock, 4096 video-only cycles -> locked and symbol_valid fall; re-inserting tokens relocks at the same offset.
- Offset wrap: stream aligned at offset 0 with the search started at offset 1 -> offset steps 1..9, wraps to 0, then locks at 0.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: aligns unaligned 10-bit deserializer words to the
// symbol boundary using control tokens, then decodes each aligned symbol
// into a video byte or a control pair. Optional TERC4 decode is enabled
// with the TMDS_TERC4_DECODE_EN macro.
//
// state   | meaning
// SEARCH  | scanning bit offsets for a control token
// CONFIRM | counting consecutive tokens at the candidate offset
// LOCKED  | aligned; symbols are decoded and marked valid
module tmds_channel_decoder #(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_raw,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       symbol_valid,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
`ifdef TMDS_TERC4_DECODE_EN
  ,
  output logic       terc4_hit,
  output logic [3:0] terc4
`endif
);

  localparam int WIN_W  = $clog2(SEARCH_WINDOW);
  localparam int LOSS_W = $clog2(LOSS_WINDOW);
  localparam int TOK_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);
  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  state_t            state, state_n;
  logic [3:0]        offset_n;
  logic [WIN_W-1:0]  win_cnt, win_cnt_n;
  logic [LOSS_W-1:0] loss_cnt, loss_cnt_n;
  logic [TOK_W-1:0]  tok_cnt, tok_cnt_n;
  logic [1:0]        skip_cnt, skip_cnt_n;

  logic [9:0]  cur, prev;
  logic [19:0] hist;
  logic [9:0]  w;
  logic [7:0]  wv;
  logic [7:0]  vid;
  logic        tok_hit, tok_ok;
  logic [1:0]  tok_ctrl;
  logic [3:0]  offset_inc;

  // Stage 1: two-word history so any 10-bit window can be extracted.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cur  <= '0;
      prev <= '0;
    end else begin
      prev <= cur;
      cur  <= tmds_raw;
    end
  end

  assign hist = {cur, prev};
  assign w    = hist[bit_offset +: 10];

  // Control token match.
  always_comb begin
    tok_hit  = 1'b1;
    tok_ctrl = 2'b00;
    case (w)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        tok_hit  = 1'b0;
    endcase
  end

  // Video decode: undo optional inversion, then undo XOR/XNOR chaining.
  always_comb begin
    wv     = w[9] ? ~w[7:0] : w[7:0];
    vid    = '0;
    vid[0] = wv[0];
    for (int i = 1; i < 8; i++)
      vid[i] = w[8] ? (wv[i] ^ wv[i-1]) : ~(wv[i] ^ wv[i-1]);
  end

`ifdef TMDS_TERC4_DECODE_EN
  logic       t4_hit;
  logic [3:0] t4_val;

  // TERC4 lookup, in parallel with video decode.
  always_comb begin
    t4_hit = 1'b1;
    t4_val = 4'h0;
    case (w)
      10'b1010011100: t4_val = 4'h0;
      10'b1001100011: t4_val = 4'h1;
      10'b1011100100: t4_val = 4'h2;
      10'b1011100010: t4_val = 4'h3;
      10'b0101110001: t4_val = 4'h4;
      10'b0100011110: t4_val = 4'h5;
      10'b0110001110: t4_val = 4'h6;
      10'b0100111100: t4_val = 4'h7;
      10'b1011001100: t4_val = 4'h8;
      10'b0100111001: t4_val = 4'h9;
      10'b0110011100: t4_val = 4'hA;
      10'b1011000110: t4_val = 4'hB;
      10'b1010001110: t4_val = 4'hC;
      10'b1001110001: t4_val = 4'hD;
      10'b0101100011: t4_val = 4'hE;
      10'b1011000011: t4_val = 4'hF;
      default:        t4_hit = 1'b0;
    endcase
  end
`endif

  // History is stale for two cycles after the offset moves.
  assign tok_ok     = tok_hit && (skip_cnt == 2'd0);
  assign offset_inc = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
  assign locked     = (state == LOCKED);

  // FSM state and counter registers.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      bit_offset <= '0;
      win_cnt    <= '0;
      loss_cnt   <= '0;
      tok_cnt    <= '0;
      skip_cnt   <= '0;
    end else begin
      state      <= state_n;
      bit_offset <= offset_n;
      win_cnt    <= win_cnt_n;
      loss_cnt   <= loss_cnt_n;
      tok_cnt    <= tok_cnt_n;
      skip_cnt   <= skip_cnt_n;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n    = state;
    offset_n   = bit_offset;
    win_cnt_n  = win_cnt;
    loss_cnt_n = loss_cnt;
    tok_cnt_n  = tok_cnt;
    skip_cnt_n = (skip_cnt != 2'd0) ? skip_cnt - 2'd1 : 2'd0;
    case (state)
      SEARCH: begin
        if (tok_ok) begin
          state_n   = CONFIRM;
          tok_cnt_n = TOK_W'(1);
          win_cnt_n = '0;
        end else if (win_cnt == WIN_LAST) begin
          offset_n   = offset_inc;
          win_cnt_n  = '0;
          skip_cnt_n = 2'd2;
        end else begin
          win_cnt_n = win_cnt + WIN_W'(1);
        end
      end
      CONFIRM: begin
        if (tok_ok) begin
          if (tok_cnt >= TOK_LAST) begin
            state_n    = LOCKED;
            tok_cnt_n  = '0;
            loss_cnt_n = '0;
          end else begin
            tok_cnt_n = tok_cnt + TOK_W'(1);
          end
        end else begin
          state_n    = SEARCH;
          offset_n   = offset_inc;
          tok_cnt_n  = '0;
          win_cnt_n  = '0;
          skip_cnt_n = 2'd2;
        end
      end
      LOCKED: begin
        if (tok_ok) begin
          loss_cnt_n = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_n    = SEARCH;
          loss_cnt_n = '0;
          tok_cnt_n  = '0;
          win_cnt_n  = '0;
        end else begin
          loss_cnt_n = loss_cnt + LOSS_W'(1);
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  // Stage 2: decoded outputs, held at zero while not locked.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      symbol_valid <= 1'b0;
      is_ctrl      <= 1'b0;
      ctrl         <= '0;
      data         <= '0;
`ifdef TMDS_TERC4_DECODE_EN
      terc4_hit    <= 1'b0;
      terc4        <= '0;
`endif
    end else begin
      symbol_valid <= locked;
      is_ctrl      <= locked & tok_hit;
      ctrl         <= locked ? tok_ctrl : 2'b00;
      data         <= locked ? vid : 8'h00;
`ifdef TMDS_TERC4_DECODE_EN
      terc4_hit    <= locked & t4_hit;
      terc4        <= locked ? t4_val : 4'h0;
`endif
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: vector table for decode plus
// hand-written sequences for alignment, confirm failure, wrap, loss, reset.
module tb_tmds_channel_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] VID0  = 10'b0100000000;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tmds_raw = '0;
  logic       locked, symbol_valid, is_ctrl;
  logic [3:0] bit_offset;
  logic [1:0] ctrl;
  logic [7:0] data;
`ifdef TMDS_TERC4_DECODE_EN
  logic       terc4_hit;
  logic [3:0] terc4;
`endif

  tmds_channel_decoder dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .tmds_raw     (tmds_raw),
    .locked       (locked),
    .bit_offset   (bit_offset),
    .symbol_valid (symbol_valid),
    .is_ctrl      (is_ctrl),
    .ctrl         (ctrl),
    .data         (data)
`ifdef TMDS_TERC4_DECODE_EN
    ,
    .terc4_hit    (terc4_hit),
    .terc4        (terc4)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int failures = 0;
  int skew = 0;
  logic [9:0] prev_w = TOK00;

  typedef struct {
    logic [9:0] w;
    logic       exp_is_ctrl;
    logic [1:0] exp_ctrl;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Serialize one word onto the raw bus with the current skew; returns
  // 1 time unit after the rising edge that samples it.
  task automatic send(input logic [9:0] wd);
    logic [19:0] cat;
    cat = {wd, prev_w};
    @(negedge clk_pixel);
    tmds_raw = cat[10 - skew +: 10];
    prev_w = wd;
    @(posedge clk_pixel);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  last_off;
    bit  saw9, step_bad, gate_bad;
    vec_t v;

    vecs[0]  = '{10'b0100000000, 1'b0, 2'b00, 8'h00};
    vecs[1]  = '{10'b1011111111, 1'b0, 2'b00, 8'hFE};
    vecs[2]  = '{TOK00,          1'b1, 2'b00, 8'h00};
    vecs[3]  = '{TOK01,          1'b1, 2'b01, 8'h00};
    vecs[4]  = '{10'b0100000001, 1'b0, 2'b00, 8'h03};
    vecs[5]  = '{TOK10,          1'b1, 2'b10, 8'h00};
    vecs[6]  = '{10'b0000000001, 1'b0, 2'b00, 8'hFD};
    vecs[7]  = '{TOK11,          1'b1, 2'b11, 8'h00};
    vecs[8]  = '{10'b1110101010, 1'b0, 2'b00, 8'hFF};
    vecs[9]  = '{10'b0111110000, 1'b0, 2'b00, 8'h10};
    vecs[10] = '{10'b1000001111, 1'b0, 2'b00, 8'hEE};

    // Reset state.
    repeat (2) @(negedge clk_pixel);
    chk("rst_locked", locked, 0);
    chk("rst_valid", symbol_valid, 0);
    chk("rst_offset", bit_offset, 0);
    chk("rst_outs", {is_ctrl, ctrl, data}, 0);
    reset = 1'b0;

    // CONFIRM failure at offset 0: three tokens then a video symbol.
    skew = 0;
    send(TOK00); send(TOK00); send(TOK00); send(VID0);
    send(TOK00);
    chk("cf_offset_before", bit_offset, 0);
    send(TOK00);
    chk("cf_offset_after", bit_offset, 1);
    chk("cf_locked", locked, 0);

    // Offset wrap: search continues from 1 while the stream sits at 0.
    last_off = 1; saw9 = 0; step_bad = 0;
    for (int i = 0; i < 25000 && !locked; i++) begin
      send(TOK00);
      if (int'(bit_offset) != last_off) begin
        if (int'(bit_offset) != ((last_off == 9) ? 0 : last_off + 1)) step_bad = 1;
        last_off = int'(bit_offset);
      end
      if (bit_offset == 4'd9) saw9 = 1;
    end
    chk("wrap_locked", locked, 1);
    chk("wrap_offset", bit_offset, 0);
    chk("wrap_saw9", saw9, 1);
    chk("wrap_step", step_bad, 0);
    send(TOK00); send(TOK00);
    chk("wrap_valid", symbol_valid, 1);

    // Mid-stream asynchronous reset.
    #2 reset = 1'b1;
    #1;
    chk("mrst_locked", locked, 0);
    chk("mrst_valid", symbol_valid, 0);
    chk("mrst_offset", bit_offset, 0);
    chk("mrst_outs", {is_ctrl, ctrl, data}, 0);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    reset = 1'b0;

    // Alignment with a 3-bit skew.
    skew = 3; prev_w = TOK00; gate_bad = 0;
    for (int i = 0; i < 10000 && !locked; i++) begin
      send(TOK00);
      if (!symbol_valid && (is_ctrl || ctrl != 2'b00 || data != 8'h00)) gate_bad = 1;
    end
    chk("align_locked", locked, 1);
    chk("align_offset", bit_offset, 3);
    chk("align_gate", gate_bad, 0);
    send(TOK00);
    for (int i = 0; i < 3; i++) begin
      send(TOK00);
      chk("align_valid", symbol_valid, 1);
      chk("align_is_ctrl", is_ctrl, 1);
      chk("align_ctrl", ctrl, 2'b00);
    end

    // Decode table: the word sent k calls ago appears after call k+2.
    for (int i = 0; i < 13; i++) begin
      send((i < 11) ? vecs[i].w : TOK00);
      if (i >= 2) begin
        v = vecs[i-2];
        chk("tab_valid", symbol_valid, 1);
        chk("tab_is_ctrl", is_ctrl, v.exp_is_ctrl);
        if (v.exp_is_ctrl) chk("tab_ctrl", ctrl, v.exp_ctrl);
        else chk("tab_data", data, v.exp_data);
      end
    end

    // Loss of lock after 4096 evaluated video symbols.
    for (int m = 1; m <= 4099; m++) begin
      send(VID0);
      if (m == 4097) chk("loss_still_locked", locked, 1);
      if (m == 4098) begin
        chk("loss_locked", locked, 0);
        chk("loss_valid_lag", symbol_valid, 1);
      end
      if (m == 4099) chk("loss_valid", symbol_valid, 0);
    end
    chk("loss_offset", bit_offset, 3);

    // Relock at the same offset.
    for (int i = 0; i < 200 && !locked; i++) send(TOK00);
    chk("relock_locked", locked, 1);
    chk("relock_offset", bit_offset, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
